// File: rtl/apb_arbiter_if.sv
// rtl/apb_arbiter_if.sv - requester-side and APB-side signal bundle for apb_arbiter
interface apb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [NREQ-1:0]    gnt;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [AW-1:0]      PRWADDR;
    logic [DW-1:0]      PRWDATA;
    logic [DW-1:0]      PRDATA;
    logic               PREADY;

    // master: the arbiter itself (APB master, requester-facing responder)
    modport master (
        input  req, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output done, err, rdata, gnt, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  done, err, rdata, gnt, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );
endinterface

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin arbiter sharing one APB master port among NREQ requesters
module apb_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [IW-1:0]   PTR_RST = IW'(NREQ - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t          r_state,   w_state_nxt;
    logic [IW-1:0]   r_ptr,     w_ptr_nxt;
    logic [IW-1:0]   r_win,     w_win_nxt;
    logic [CW-1:0]   r_cnt,     w_cnt_nxt;
    logic            r_psel,    w_psel_nxt;
    logic            r_penable, w_penable_nxt;
    logic            r_pwrite,  w_pwrite_nxt;
    logic [AW-1:0]   r_paddr,   w_paddr_nxt;
    logic [DW-1:0]   r_pwdata,  w_pwdata_nxt;
    logic [NREQ-1:0] r_gnt,     w_gnt_nxt;
    logic [NREQ-1:0] r_done,    w_done_nxt;
    logic            r_err,     w_err_nxt;
    logic [DW-1:0]   r_rdata,   w_rdata_nxt;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IW-1:0]   w_pick;

    // A requester still sees its own done this cycle; masking it avoids a duplicate issue.
    assign w_elig = bus.req & ~r_done;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_cnt_nxt     = r_cnt;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = S_SETUP;
                    w_win_nxt     = w_pick;
                    w_ptr_nxt     = w_pick;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = bus.req_write[w_pick];
                    w_paddr_nxt   = bus.req_addr[int'(w_pick)*AW +: AW];
                    w_pwdata_nxt  = bus.req_wdata[int'(w_pick)*DW +: DW];
                    w_gnt_nxt     = ONE_HOT << w_pick;
                end else begin
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = 1'b0;
                    w_paddr_nxt   = '0;
                    w_pwdata_nxt  = '0;
                    w_gnt_nxt     = '0;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    w_state_nxt        = S_IDLE;
                    w_done_nxt[r_win]  = 1'b1;
                    w_psel_nxt         = 1'b0;
                    w_penable_nxt      = 1'b0;
                    w_gnt_nxt          = '0;
                    if (!r_pwrite) begin
                        w_rdata_nxt = bus.PRDATA;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt        = S_IDLE;
                    w_done_nxt[r_win]  = 1'b1;
                    w_err_nxt          = 1'b1;
                    w_rdata_nxt        = '0;
                    w_psel_nxt         = 1'b0;
                    w_penable_nxt      = 1'b0;
                    w_gnt_nxt          = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_ptr     <= PTR_RST;
            r_win     <= '0;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_cnt     <= w_cnt_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign bus.PSEL    = r_psel;
    assign bus.PENABLE = r_penable;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PRWADDR = r_paddr;
    assign bus.PRWDATA = r_pwdata;
    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - scenario bench for apb_arbiter with a completion scoreboard
module tb_apb_arbiter;
    localparam int NREQ    = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [NREQ-1:0] done;
        logic            err;
        logic [DW-1:0]   rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.done  = '0;
        e.err   = 1'b0;
        e.rdata = '0;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic wait_done(input int limit, output bit seen, output int pen);
        seen = 1'b0;
        pen  = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (bus.PENABLE) pen++;
            if (|bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        PRESET        = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000 || bus.PRWADDR !== '0 || bus.PRWDATA !== '0 ||
            bus.gnt !== '0 || bus.done !== '0 || bus.err !== 1'b0 || bus.rdata !== '0) begin
            bad++;
            $display("FAIL reset_state: psel=%b pen=%b pw=%b addr=%h wd=%h gnt=%b done=%b err=%b rdata=%h, required all 0",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PRWADDR, bus.PRWDATA, bus.gnt, bus.done, bus.err, bus.rdata);
        end
        PRESET = 1'b0;
        tick();
        total++;
        if (bus.PSEL !== 1'b0 || bus.gnt !== '0) begin
            bad++;
            $display("FAIL idle_no_req: psel=%b gnt=%b, required 0 0", bus.PSEL, bus.gnt);
        end
    endtask

    task automatic test_write_zero_wait();
        exp_t e;
        bus.PREADY             = 1'b1;
        bus.req_write[0]       = 1'b1;
        bus.req_addr[0 +: AW]  = 32'h4;
        bus.req_wdata[0 +: DW] = 32'hDEADBEEF;
        bus.req[0]             = 1'b1;
        sb.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h0});
        tick();
        total++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.gnt !== 2'b01 || bus.PWRITE !== 1'b1 ||
            bus.PRWADDR !== 32'h4 || bus.PRWDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_setup: psel=%b pen=%b gnt=%b pw=%b addr=%h wd=%h, required 1 0 01 1 4 deadbeef",
                     bus.PSEL, bus.PENABLE, bus.gnt, bus.PWRITE, bus.PRWADDR, bus.PRWDATA);
        end
        tick();
        total++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 || bus.PRWADDR !== 32'h4 || bus.PRWDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_access: psel=%b pen=%b addr=%h wd=%h, required 1 1 4 deadbeef",
                     bus.PSEL, bus.PENABLE, bus.PRWADDR, bus.PRWDATA);
        end
        tick();
        e = pop_exp();
        total++;
        if (bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
            bad++;
            $display("FAIL wr_done: done=%b err=%b rdata=%h, required %b %b %h",
                     bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
        end
        total++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.gnt !== '0) begin
            bad++;
            $display("FAIL wr_release: psel=%b pen=%b gnt=%b, required 0 0 00", bus.PSEL, bus.PENABLE, bus.gnt);
        end
        bus.req[0] = 1'b0;
        tick();
        total++;
        if (bus.done !== '0) begin
            bad++;
            $display("FAIL done_pulse: done=%b, required 00", bus.done);
        end
    endtask

    task automatic test_read_wait();
        exp_t e;
        bit   seen;
        int   pen;
        bus.PREADY              = 1'b0;
        bus.PRDATA              = 32'h12345678;
        bus.req_write[1]        = 1'b0;
        bus.req_addr[AW +: AW]  = 32'h8;
        bus.req[1]              = 1'b1;
        sb.push_back('{done: 2'b10, err: 1'b0, rdata: 32'h12345678});
        seen = 1'b0;
        pen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.PENABLE) pen++;
            bus.PREADY = (pen >= 4);
            if (|bus.done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rd_wait_bound: done seen=%0d, required 1", seen);
        end
        total++;
        if (pen != 4) begin
            bad++;
            $display("FAIL rd_penable_cycles: got %0d, required 4", pen);
        end
        e = pop_exp();
        total++;
        if (bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
            bad++;
            $display("FAIL rd_done: done=%b err=%b rdata=%h, required %b %b %h",
                     bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
        end
        bus.req[1] = 1'b0;
        bus.PREADY = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        exp_t            e;
        logic [NREQ-1:0] exp_g [4];
        logic [NREQ-1:0] prev_gnt;
        int              ng;
        int              nd;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus.PREADY              = 1'b1;
        bus.PRDATA              = 32'hC0FFEE00;
        bus.req_write           = 2'b00;
        bus.req_addr[0 +: AW]   = 32'h10;
        bus.req_addr[AW +: AW]  = 32'h14;
        for (int i = 0; i < 4; i++) sb.push_back('{done: exp_g[i], err: 1'b0, rdata: 32'hC0FFEE00});
        bus.req  = 2'b11;
        prev_gnt = '0;
        ng       = 0;
        nd       = 0;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            tick();
            if (bus.gnt !== '0 && prev_gnt === '0 && ng < 4) begin
                total++;
                if (bus.gnt !== exp_g[ng]) begin
                    bad++;
                    $display("FAIL cont_grant%0d: gnt=%b, required %b", ng, bus.gnt, exp_g[ng]);
                end
                ng++;
            end
            prev_gnt = bus.gnt;
            if (|bus.done) begin
                e = pop_exp();
                total++;
                if (bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL cont_done%0d: done=%b err=%b rdata=%h, required %b %b %h",
                             nd, bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
                end
                nd++;
                if (nd == 4) bus.req = 2'b00;
            end
        end
        total++;
        if (nd != 4 || ng != 4) begin
            bad++;
            $display("FAIL cont_count: grants=%0d dones=%0d, required 4 4", ng, nd);
        end
        tick();
        total++;
        if (bus.gnt !== '0 || bus.PSEL !== 1'b0) begin
            bad++;
            $display("FAIL cont_quiet: gnt=%b psel=%b, required 00 0", bus.gnt, bus.PSEL);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen;
        int   pen;
        bus.PREADY             = 1'b0;
        bus.req_write[0]       = 1'b1;
        bus.req_addr[0 +: AW]  = 32'h20;
        bus.req_wdata[0 +: DW] = 32'h1;
        bus.req[0]             = 1'b1;
        sb.push_back('{done: 2'b01, err: 1'b1, rdata: 32'h0});
        wait_done(60, seen, pen);
        total++;
        if (!seen || pen != TIMEOUT) begin
            bad++;
            $display("FAIL to_cycles: seen=%0d penable_cycles=%0d, required 1 %0d", seen, pen, TIMEOUT);
        end
        e = pop_exp();
        total++;
        if (bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata || bus.PSEL !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: done=%b err=%b rdata=%h psel=%b, required %b %b %h 0",
                     bus.done, bus.err, bus.rdata, bus.PSEL, e.done, e.err, e.rdata);
        end
        bus.req[0] = 1'b0;
        tick();
        total++;
        if (bus.err !== 1'b0 || bus.done !== '0) begin
            bad++;
            $display("FAIL err_pulse: err=%b done=%b, required 0 00", bus.err, bus.done);
        end
        bus.PREADY       = 1'b1;
        bus.PRDATA       = 32'hA5A50001;
        bus.req_write[1] = 1'b0;
        bus.req[1]       = 1'b1;
        sb.push_back('{done: 2'b10, err: 1'b0, rdata: 32'hA5A50001});
        wait_done(10, seen, pen);
        e = pop_exp();
        total++;
        if (!seen || bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
            bad++;
            $display("FAIL to_recover: seen=%0d done=%b err=%b rdata=%h, required 1 %b %b %h",
                     seen, bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
        end
        bus.req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        int   pen;
        bus.PREADY             = 1'b0;
        bus.req_write          = 2'b11;
        bus.req_addr[0 +: AW]  = 32'h30;
        bus.req_addr[AW +: AW] = 32'h34;
        bus.req[0]             = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (bus.PENABLE !== 1'b1 || bus.gnt !== 2'b01) begin
            bad++;
            $display("FAIL rst_pre_access: pen=%b gnt=%b, required 1 01", bus.PENABLE, bus.gnt);
        end
        PRESET     = 1'b1;
        bus.req[1] = 1'b1;
        tick();
        total++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.gnt !== '0 || bus.done !== '0 || bus.rdata !== '0) begin
            bad++;
            $display("FAIL rst_abort: psel=%b pen=%b gnt=%b done=%b rdata=%h, required 0 0 00 00 0",
                     bus.PSEL, bus.PENABLE, bus.gnt, bus.done, bus.rdata);
        end
        PRESET     = 1'b0;
        bus.PREADY = 1'b1;
        sb.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h0});
        sb.push_back('{done: 2'b10, err: 1'b0, rdata: 32'h0});
        tick();
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++;
            $display("FAIL rst_priority: gnt=%b, required 01", bus.gnt);
        end
        for (int r = 0; r < 2; r++) begin
            wait_done(10, seen, pen);
            e = pop_exp();
            total++;
            if (!seen || bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
                bad++;
                $display("FAIL rst_after%0d: seen=%0d done=%b err=%b rdata=%h, required 1 %b %b %h",
                         r, seen, bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
            end
            bus.req = bus.req & ~bus.done;
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_withdraw();
        exp_t e;
        bit   seen;
        bit   hit1;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'h5555AAAA;
        bus.req_write = 2'b00;
        bus.req[0]    = 1'b1;
        sb.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h5555AAAA});
        hit1 = 1'b0;
        tick();
        tick();
        bus.req[1] = 1'b1;
        tick();
        if (bus.gnt[1] || bus.done[1]) hit1 = 1'b1;
        bus.req[1] = 1'b0;
        bus.PREADY = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.gnt[1] || bus.done[1]) hit1 = 1'b1;
            if (|bus.done) seen = 1'b1;
        end
        e = pop_exp();
        total++;
        if (!seen || bus.done !== e.done || bus.err !== e.err || bus.rdata !== e.rdata) begin
            bad++;
            $display("FAIL wd_done: seen=%0d done=%b err=%b rdata=%h, required 1 %b %b %h",
                     seen, bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
        end
        bus.req[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.gnt[1] || bus.done[1]) hit1 = 1'b1;
        end
        total++;
        if (hit1 !== 1'b0) begin
            bad++;
            $display("FAIL wd_never_granted: requester1 activity=%b, required 0", hit1);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_empty: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one APB master port between NREQ local requesters.
- Round-robin arbitration; runs the APB SETUP/ACCESS sequence for the granted requester and waits on PREADY.
- Returns read data and a completion pulse to the granted requester.
- Sits between the requester logic and the APB slave. Drives PSEL/PENABLE/PWRITE/PRWADDR/PRWDATA; samples PREADY/PRDATA.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, max ACCESS-phase cycles waiting for PREADY before abort (>=2).

Ports:
- PCLK  in  1  clock. All logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester transfer request. Level; held until matching done.
- req_write  in  NREQ  per-requester direction (1=write).
- req_addr  in  NREQ*AW  packed addresses. Requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data, same packing.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 = transfer timed out.
- rdata  out  DW  read data, valid with done on a read.
- gnt  out  NREQ  one-hot owner of the current transfer; 0 when idle.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PRWADDR  out  AW  APB address.
- PRWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB slave ready.

Behaviour:
- All outputs are registered.
- Reset (PRESET=1 at an edge):
  - state=IDLE; PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA, gnt, done, err, rdata all 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Reset mid-transfer aborts immediately. No done is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requesters = req & ~done (masks a requester completing this cycle, so one request is never double-issued).
  - If any are eligible, grant the first one scanning upward from pointer+1 with wrap-around.
  - On grant, latch addr/wdata/write into the PRWADDR/PRWDATA/PWRITE registers, set gnt, PSEL=1, PENABLE=0, update pointer to the winner, go to SETUP.
  - If none are eligible, stay in IDLE with all APB outputs 0.
- SETUP: one cycle. Next edge sets PENABLE=1, clears the wait counter, goes to ACCESS.
- ACCESS:
  - PREADY=1 at the edge:
    - done[winner]=1, err=0.
    - On a read, rdata=PRDATA; on a write, rdata holds its previous value.
    - PSEL=0, PENABLE=0, gnt=0, go to IDLE.
  - PREADY=0: increment the wait counter.
  - Counter reaching TIMEOUT-1 with PREADY still 0 at the edge:
    - Abort: done[winner]=1, err=1, rdata=0.
    - PSEL=0, PENABLE=0, go to IDLE.
  - PRWADDR/PRWDATA/PWRITE stay stable from SETUP through the end of ACCESS.
  - req changes while granted are ignored. req_addr/req_wdata are not re-sampled.
- done and err are single-cycle pulses; both clear on the next edge.
- Minimum latency, zero-wait slave (req high before edge 0):
  - PSEL after edge 0.
  - PENABLE after edge 1.
  - done after edge 2.
  - Earliest next SETUP after edge 3.
- Simultaneous requests: strict round-robin. No requester waits more than NREQ-1 transfers.
- Dropping req before grant withdraws the request. Dropping it after grant does not cancel the transfer.
- Wait counter is wide enough for TIMEOUT-1 and has no wrap-around; it saturates by the abort rule.

Test Plan:
1. Write, zero-wait:
   - Stimulus: requester 0 req=1, write, addr=0x4, wdata=0xDEADBEEF; PREADY tied 1.
   - Response: PSEL rises after edge 0, PENABLE after edge 1, PRWADDR=0x4, PRWDATA=0xDEADBEEF; done[0]=1, err=0 after edge 2; PSEL=PENABLE=0.
2. Read with 3 wait states:
   - Stimulus: requester 1 reads addr=0x8; slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PRDATA=0x12345678.
   - Response: PENABLE high for 4 cycles; done[1]=1 with rdata=0x12345678, err=0.
3. Contention:
   - Stimulus: NREQ=2, both req held high continuously.
   - Response: grant order 0,1,0,1; each requester is never granted twice in a row; the finishing requester is not regranted in its done cycle.
4. Timeout:
   - Stimulus: PREADY held 0, TIMEOUT=16.
   - Response: after 16 ACCESS cycles, done=1, err=1, rdata=0; PSEL drops; a subsequent normal request completes correctly.
5. Reset mid-transfer:
   - Stimulus: PRESET=1 during ACCESS.
   - Response: after the next edge, PSEL=PENABLE=0, gnt=0, no done pulse; after release, requester 0 has priority.
6. Request withdrawal:
   - Stimulus: requester 1 pulses req for one cycle while requester 0's transfer is in progress, then drops it.
   - Response: requester 1 is never granted and no done[1] is issued.
